m_phy_lane_tx_sym_sched: RTL

//  Upstream neighbour of the lane parallel-to-serial shifter. Buffers encoded 10-bit symbols

---
 rtl/m_phy_pkg.sv | 24 ++
 rtl/m_phy_sym_fifo.sv | 54 +++++
 rtl/m_phy_lane_tx_sym_sched.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/m_phy_pkg.sv
// Shared types and line-code constants for the lane transmit path.
package m_phy_pkg;

  typedef logic [9:0] sym_t;

  localparam sym_t PREP_SYM   = 10'h17C;
  localparam sym_t SYNC_SYM   = 10'h283;
  localparam sym_t MK0_SYM    = 10'h0F9;
  localparam sym_t FILLER_SYM = 10'h2A5;
  localparam sym_t TAIL_SYM   = 10'h1E3;

  // Last bit position within a 10-bit symbol.
  localparam logic [3:0] BIT_LAST = 4'd9;

  typedef enum logic [2:0] {
    IDLE,
    PREPARE,
    SYNC,
    MARKER,
    DATA,
    DRAIN
  } tx_sched_state_e;

endpackage

// File: rtl/m_phy_sym_fifo.sv
// Synchronous symbol FIFO with first-word-fall-through head and registered level.
module m_phy_sym_fifo
  import m_phy_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int LW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  sym_t          push_data,
  input  logic          pop,
  output sym_t          head,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  sym_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/m_phy_lane_tx_sym_sched.sv
// Lane transmit symbol scheduler: buffers encoded symbols and frames bursts
// (PREPARE, SYNC, MK0, data/FILLER, TAIL) into one shifter load per 10 bit strobes.
module m_phy_lane_tx_sym_sched
  import m_phy_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int PREP_LEN   = 4,
  parameter int SYNC_LEN   = 2,
  localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          burst_req,
  input  logic          s_valid,
  input  logic [9:0]    s_data,
  output logic          s_ready,
  output logic          load,
  output logic [9:0]    parallel_out,
  output logic          burst_active,
  output logic [LW-1:0] fifo_level
);

  localparam int MAXLEN = (PREP_LEN > SYNC_LEN) ? PREP_LEN : SYNC_LEN;
  localparam int SCW    = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

  tx_sched_state_e state, state_nxt;
  logic [3:0]      bit_cnt, bit_cnt_nxt;
  logic [SCW-1:0]  sym_cnt, sym_cnt_nxt;
  logic            boundary;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  sym_t            head;

  assign s_ready      = !full;
  assign push         = s_valid && s_ready;
  assign burst_active = (state != IDLE);
  assign boundary     = enable && (bit_cnt == '0) && (state != IDLE);

  m_phy_sym_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(s_data),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .level    (fifo_level)
  );

  // State, bit position and framing-symbol counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      sym_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      sym_cnt <= sym_cnt_nxt;
    end
  end

  // Next-state, symbol selection and load generation at symbol boundaries.
  always_comb begin
    state_nxt    = state;
    sym_cnt_nxt  = sym_cnt;
    load         = 1'b0;
    parallel_out = '0;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        if (burst_req) begin
          state_nxt   = PREPARE;
          sym_cnt_nxt = '0;
        end
      end
      PREPARE: begin
        if (boundary) begin
          load         = 1'b1;
          parallel_out = PREP_SYM;
          if (sym_cnt == SCW'(PREP_LEN - 1)) begin
            state_nxt   = SYNC;
            sym_cnt_nxt = '0;
          end else begin
            sym_cnt_nxt = sym_cnt + SCW'(1);
          end
        end
      end
      SYNC: begin
        if (boundary) begin
          load         = 1'b1;
          parallel_out = SYNC_SYM;
          if (sym_cnt == SCW'(SYNC_LEN - 1)) begin
            state_nxt   = MARKER;
            sym_cnt_nxt = '0;
          end else begin
            sym_cnt_nxt = sym_cnt + SCW'(1);
          end
        end
      end
      MARKER: begin
        if (boundary) begin
          load         = 1'b1;
          parallel_out = MK0_SYM;
          state_nxt    = DATA;
        end
      end
      DATA: begin
        if (boundary) begin
          load = 1'b1;
          if (!empty) begin
            parallel_out = head;
            pop          = 1'b1;
          end else if (burst_req) begin
            parallel_out = FILLER_SYM;
          end else begin
            parallel_out = TAIL_SYM;
            state_nxt    = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (boundary) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit position: pinned to 0 in IDLE and on the way into or out of it so that
  // the first PREPARE load lands on the first enabled cycle of a burst.
  always_comb begin
    bit_cnt_nxt = bit_cnt;
    if (state == IDLE || state_nxt == IDLE) begin
      bit_cnt_nxt = '0;
    end else if (enable) begin
      bit_cnt_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 4'd1;
    end
  end

endmodule
